serial_deser: RTL

SERIAL_DESER -- requirements
Module: serial_deser

---
 rtl/ser_pkg.sv | 10 +
 rtl/ser_bit_cnt.sv | 31 +++
 rtl/serial_deser.sv | 117 +++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial deserialiser: FSM state encoding and
// the default word length.
package ser_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/ser_bit_cnt.sv
// Bit-position counter for serial_deser with terminal-count detect.
// clr together with inc restarts the count at 1 (new frame's bit 0 accepted).
module ser_bit_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] base;

    assign last = (count == TERM);
    assign base = clr ? '0 : count;

    // Wrap explicitly at WIDTH-1 so non-power-of-two widths never reach unused codes
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            count <= '0;
        end else if (inc) begin
            count <= (last && !clr) ? '0 : base + CNT_W'(1);
        end else begin
            count <= base;
        end
    end
endmodule

// File: rtl/serial_deser.sv
// Collects an LSB-first serial bit stream into parallel words and presents
// them on a registered valid/ready port with framing-error and overflow flags.
module serial_deser
    import ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             ferr,
    output logic             ovf,
    output logic             busy
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             done;
    logic             ferr_nxt;

    ser_bit_cnt #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_cnt (
        .t_clk(t_clk),
        .r    (r),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .count(count),
        .last (last)
    );

    assign busy = (state == COLLECT);

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        done      = 1'b0;
        ferr_nxt  = 1'b0;
        if (sin_vld) begin
            case (state)
                IDLE: begin
                    if (sof) begin
                        sreg_nxt[0] = sin;
                        cnt_inc     = 1'b1;
                        cnt_clr     = 1'b1;
                        state_nxt   = COLLECT;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
                COLLECT: begin
                    // A fresh sof mid-frame abandons the partial word and restarts at bit 0
                    if (sof) begin
                        ferr_nxt    = 1'b1;
                        sreg_nxt[0] = sin;
                        cnt_inc     = 1'b1;
                        cnt_clr     = 1'b1;
                    end else begin
                        sreg_nxt[count] = sin;
                        cnt_inc         = 1'b1;
                        if (last) begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output register: a completed word is dropped only if the held one is not leaving
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            sreg     <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ferr     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            sreg <= sreg_nxt;
            ferr <= ferr_nxt;
            if (done) begin
                if (!dout_vld || dout_rdy) begin
                    dout     <= sreg_nxt;
                    dout_vld <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (dout_rdy) begin
                dout_vld <= 1'b0;
            end
        end
    end
endmodule
